// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the PISO serializer.
package piso_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  localparam int PARITY_MAX_W = 64;

  // Callers zero-extend their word to PARITY_MAX_W; zero bits do not change the XOR.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/piso_serializer_mod_counter.sv
// Modulo-MAX up-counter with sync clear, enable and a same-cycle wrap pulse.
module mod_counter #(
  parameter int MAX = 4,
  parameter int W   = (MAX > 1) ? $clog2(MAX) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_wrap
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] r_count;

  assign o_count = r_count;
  assign o_wrap  = i_en && (r_count == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_wrap ? '0 : r_count + W'(1);
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with valid/ready load, bit counter and wrapping word counter.
// Optional trailing even-parity bit when PISO_SERIALIZER_PARITY_EN is defined.
//
// state     | meaning
// ST_IDLE   | no live bit, ready for a word
// ST_SHIFT  | data bits being presented on ser_out
// ST_PARITY | parity bit being presented (parity build only)
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0,
  parameter int MAX_WORDS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         shift_en,
  output logic                         ser_out,
  output logic                         ser_valid,
  output logic                         done,
  output logic [$clog2(MAX_WORDS)-1:0] word_count,
  output logic                         words_max
);

  localparam int CNT_W = $clog2(MAX_WORDS);
  localparam int BIT_W = $clog2(WIDTH);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shifted;
  logic [BIT_W-1:0] w_bit_cnt;
  logic             w_bit_wrap;
  logic             w_bit_en;
  logic             w_last_pos;
  logic             w_word_end;
  logic             w_accept;
  logic             w_head;
  logic [CNT_W-1:0] w_word_cnt;
  logic             w_word_wrap;

  assign w_accept = in_valid && in_ready;
  assign w_bit_en = (r_state == ST_SHIFT) && shift_en;
  assign w_head   = (LSB_FIRST != 0) ? r_shreg[0] : r_shreg[WIDTH-1];
  assign w_shifted = (LSB_FIRST != 0) ? (r_shreg >> 1) : (r_shreg << 1);

`ifdef PISO_SERIALIZER_PARITY_EN
  logic                    r_parity;
  logic [PARITY_MAX_W-1:0] w_par_vec;

  assign w_par_vec  = PARITY_MAX_W'(in_data);
  assign w_last_pos = (r_state == ST_PARITY);
  assign ser_out    = (r_state == ST_SHIFT)  ? w_head   :
                      (r_state == ST_PARITY) ? r_parity : 1'b0;
`else
  assign w_last_pos = (r_state == ST_SHIFT) && (w_bit_cnt == BIT_LAST);
  assign ser_out    = (r_state == ST_SHIFT) ? w_head : 1'b0;
`endif

  assign w_word_end = w_last_pos && shift_en;
  // Gated by rst so in_ready reads 0 while reset is held.
  assign in_ready   = rst && ((r_state == ST_IDLE) || w_word_end);
  assign ser_valid  = (r_state != ST_IDLE);
  assign done       = w_word_end;
  assign words_max  = w_word_wrap;
  assign word_count = w_word_cnt;

  mod_counter #(.MAX(WIDTH), .W(BIT_W)) u_bit_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_accept),
    .i_en    (w_bit_en),
    .o_count (w_bit_cnt),
    .o_wrap  (w_bit_wrap)
  );

  mod_counter #(.MAX(MAX_WORDS), .W(CNT_W)) u_word_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (1'b0),
    .i_en    (w_word_end),
    .o_count (w_word_cnt),
    .o_wrap  (w_word_wrap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_shreg  <= '0;
`ifdef PISO_SERIALIZER_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else if (w_accept) begin
      r_shreg  <= in_data;
      r_state  <= ST_SHIFT;
`ifdef PISO_SERIALIZER_PARITY_EN
      r_parity <= even_parity(w_par_vec);
`endif
    end else begin
      case (r_state)
        ST_SHIFT: begin
          if (shift_en) begin
            r_shreg <= w_shifted;
`ifdef PISO_SERIALIZER_PARITY_EN
            if (w_bit_wrap) r_state <= ST_PARITY;
`else
            if (w_bit_wrap) r_state <= ST_IDLE;
`endif
          end
        end
`ifdef PISO_SERIALIZER_PARITY_EN
        ST_PARITY: begin
          if (shift_en) r_state <= ST_IDLE;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB and LSB instances, hand-computed bit streams.
module tb_piso_serializer;

  localparam int W = 8;
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid, a_shift, b_shift;
  logic       a_ready, a_ser, a_sv, a_done, a_wmax;
  logic       b_ready, b_ser, b_sv, b_done, b_wmax;
  logic [1:0] a_wc, b_wc;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .LSB_FIRST(0), .MAX_WORDS(4)) u_msb (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .shift_en(a_shift), .ser_out(a_ser), .ser_valid(a_sv), .done(a_done),
    .word_count(a_wc), .words_max(a_wmax)
  );

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1), .MAX_WORDS(4)) u_lsb (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .shift_en(b_shift), .ser_out(b_ser), .ser_valid(b_sv), .done(b_done),
    .word_count(b_wc), .words_max(b_wmax)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Bit i of a word as it should appear on the wire; index W is the parity bit.
  function automatic logic exp_bit(input logic [7:0] w, input int i, input bit lsb);
    if (i >= W) return ^w;
    return lsb ? w[i] : w[W-1-i];
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] w, input int wc_after);
    step;
    a_data  = w;
    a_valid = 1'b1;
    a_shift = 1'b1;
    @(negedge clk);
    chk("load_ready", a_ready, 1'b1);
    step;
    a_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      chk("ser_bit", a_ser, exp_bit(w, i, 1'b0));
      chk("ser_valid", a_sv, 1'b1);
      chk("done", a_done, (i == NB-1));
      chk("ready_low", a_ready, (i == NB-1));
      chk("wmax", a_wmax, 1'b0);
      step;
    end
    @(negedge clk);
    chk("idle_sv", a_sv, 1'b0);
    chk("idle_ser", a_ser, 1'b0);
    chk("wc", a_wc, wc_after);
  endtask

  initial begin
    a_data = '0; a_valid = 1'b0; a_shift = 1'b0;
    b_data = '0; b_valid = 1'b0; b_shift = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sv", a_sv, 1'b0);
    chk("rst_ready", a_ready, 1'b0);
    chk("rst_ser", a_ser, 1'b0);
    chk("rst_wc", a_wc, 0);
    chk("rst_done", a_done, 1'b0);
    step;
    rst = 1'b1;
    @(negedge clk);
    chk("rel_ready", a_ready, 1'b1);
    chk("rel_sv", a_sv, 1'b0);

    // MSB first 0x0F, strobe every cycle (strobe during idle is ignored)
    send_a(8'h0F, 1);

    // back-to-back 0x81 then 0x7E with in_valid held
    step;
    a_data = 8'h81; a_valid = 1'b1; a_shift = 1'b1;
    step;
    a_data = 8'h7E;
    for (int i = 0; i < 2*NB; i++) begin
      @(negedge clk);
      chk("b2b_sv", a_sv, 1'b1);
      chk("b2b_bit", a_ser, exp_bit((i < NB) ? 8'h81 : 8'h7E, i % NB, 1'b0));
      chk("b2b_done", a_done, (i == NB-1) || (i == 2*NB-1));
      chk("b2b_ready", a_ready, (i == NB-1) || (i == 2*NB-1));
      chk("b2b_wmax", a_wmax, 1'b0);
      step;
      if (i == NB-1) a_valid = 1'b0;
    end
    @(negedge clk);
    chk("b2b_wc", a_wc, 3);
    chk("b2b_idle", a_sv, 1'b0);

    // 0xA5 with a strobe every third cycle; fourth word wraps the count
    step;
    a_shift = 1'b0; a_data = 8'hA5; a_valid = 1'b1;
    step;
    a_valid = 1'b0;
    for (int k = 0; k < 3*NB; k++) begin
      a_shift = ((k % 3) == 2);
      @(negedge clk);
      chk("slow_bit", a_ser, exp_bit(8'hA5, k / 3, 1'b0));
      chk("slow_done", a_done, (k == 3*NB-1));
      chk("slow_ready", a_ready, (k == 3*NB-1));
      chk("slow_wmax", a_wmax, (k == 3*NB-1));
      step;
    end
    @(negedge clk);
    chk("wrap_wc", a_wc, 0);
    chk("wrap_idle", a_sv, 1'b0);

    // reset after 3 bits of 0xFF
    step;
    a_data = 8'hFF; a_valid = 1'b1; a_shift = 1'b1;
    step;
    a_valid = 1'b0;
    step; step; step;
    @(negedge clk);
    chk("mid_sv", a_sv, 1'b1);
    step;
    rst = 1'b0;
    #1;
    chk("rstmid_sv", a_sv, 1'b0);
    chk("rstmid_done", a_done, 1'b0);
    chk("rstmid_ready", a_ready, 1'b0);
    chk("rstmid_wc", a_wc, 0);
    step;
    rst = 1'b1;
    a_shift = 1'b0;
    @(negedge clk);
    chk("rel2_ready", a_ready, 1'b1);
    chk("rel2_wc", a_wc, 0);
    chk("rel2_sv", a_sv, 1'b0);
    chk("rel2_done", a_done, 1'b0);

    // LSB-first instance, 0x0F
    step;
    b_data = 8'h0F; b_valid = 1'b1; b_shift = 1'b1;
    step;
    b_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      chk("lsb_bit", b_ser, exp_bit(8'h0F, i, 1'b1));
      chk("lsb_ready", b_ready, (i == NB-1));
      chk("lsb_done", b_done, (i == NB-1));
      step;
    end
    @(negedge clk);
    chk("lsb_wc", b_wc, 1);
    chk("lsb_idle", b_sv, 1'b0);

`ifdef PISO_SERIALIZER_PARITY_EN
    send_a(8'h07, 1);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
